// File: rtl/key_stp_pkg.sv
// Shared types and constants for the round-key serial-to-parallel collector.
package key_stp_pkg;

    localparam int BYTES_PER_RK   = 16;
    localparam int BYTE_W         = 8;
    localparam int RK_W           = 128;
    localparam int CNT_W          = 4;
    localparam int NUM_RK_DEFAULT = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } key_stp_state_e;

endpackage : key_stp_pkg

// File: rtl/key_stp_collect_rk_regfile.sv
// Round-key register file: NUM_RK x 128-bit slots, one write port and a
// registered read port. Out-of-range reads return zero.
module rk_regfile
    import key_stp_pkg::*;
#(
    parameter int NUM_RK = NUM_RK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [CNT_W-1:0]     wr_idx,
    input  logic [RK_W-1:0]      wr_data,
    input  logic [CNT_W-1:0]     rd_idx,
    output logic [RK_W-1:0]      rd_data
);

    logic [RK_W-1:0] mem_q [0:NUM_RK-1];
    logic [RK_W-1:0] mem_d [0:NUM_RK-1];
    logic [RK_W-1:0] rd_data_q;
    logic [RK_W-1:0] rd_data_d;

    // Next-state for storage and read data; the read uses the pre-write contents.
    always_comb begin
        mem_d = mem_q;
        if (we && (int'(wr_idx) < NUM_RK)) begin
            mem_d[wr_idx] = wr_data;
        end else begin
            mem_d = mem_q;
        end
        if (int'(rd_idx) < NUM_RK) begin
            rd_data_d = mem_q[rd_idx];
        end else begin
            rd_data_d = {RK_W{1'b0}};
        end
    end

    // Storage and read-data registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RK; i++) begin
                mem_q[i] <= {RK_W{1'b0}};
            end
            rd_data_q <= {RK_W{1'b0}};
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : rk_regfile

// File: rtl/key_stp_collect.sv
// Serial-to-parallel round-key collector: reassembles 16-byte frames into
// 128-bit words (first byte in [127:120]) and stores them by slot index.
// Optional inter-byte timeout: define KEY_STP_TIMEOUT_EN.
module key_stp_collect
    import key_stp_pkg::*;
#(
    parameter int NUM_RK      = NUM_RK_DEFAULT,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     kcnt,
    input  logic [BYTE_W-1:0]    din,
    input  logic                 din_valid,
    output logic                 busy,
    output logic [RK_W-1:0]      blk,
    output logic                 blk_valid,
    output logic [NUM_RK-1:0]    rk_valid,
    input  logic [CNT_W-1:0]     rd_idx,
    output logic [RK_W-1:0]      rd_data,
    output logic                 err
);

    key_stp_state_e      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [RK_W-1:0]     shift_q, shift_d;
    logic [RK_W-1:0]     blk_q, blk_d;
    logic                blk_valid_q, blk_valid_d;
    logic [NUM_RK-1:0]   rk_valid_q, rk_valid_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                we_s;
    logic [RK_W-1:0]     shift_next_s;

`ifdef KEY_STP_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
    logic [ST_W-1:0]     stall_q, stall_d;
`endif

    assign shift_next_s = {shift_q[RK_W-BYTE_W-1:0], din};

    // Frame FSM, byte assembly, sticky error and slot-valid tracking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        blk_d       = blk_q;
        blk_valid_d = 1'b0;
        rk_valid_d  = rk_valid_q;
        err_d       = err_q;
        we_s        = 1'b0;
`ifdef KEY_STP_TIMEOUT_EN
        stall_d     = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A byte arriving with start is dropped silently.
                    if (int'(kcnt) < NUM_RK) begin
                        idx_d   = kcnt;
                        cnt_d   = {CNT_W{1'b0}};
                        shift_d = {RK_W{1'b0}};
                        state_d = COLLECT;
`ifdef KEY_STP_TIMEOUT_EN
                        stall_d = {ST_W{1'b0}};
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (din_valid) begin
                    err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (start) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (din_valid) begin
                    shift_d = shift_next_s;
`ifdef KEY_STP_TIMEOUT_EN
                    stall_d = {ST_W{1'b0}};
`endif
                    if (cnt_q == 4'd15) begin
                        cnt_d       = {CNT_W{1'b0}};
                        blk_d       = shift_next_s;
                        blk_valid_d = 1'b1;
                        state_d     = COMMIT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
`ifdef KEY_STP_TIMEOUT_EN
                    if (stall_q == ST_W'(TIMEOUT_CYC - 1)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        cnt_d   = {CNT_W{1'b0}};
                        shift_d = {RK_W{1'b0}};
                        stall_d = {ST_W{1'b0}};
                    end else begin
                        stall_d = stall_q + ST_W'(1);
                    end
`else
                    state_d = COLLECT;
`endif
                end
            end
            COMMIT: begin
                we_s              = 1'b1;
                rk_valid_d[idx_q] = 1'b1;
                state_d           = IDLE;
                if (start || din_valid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            idx_q       <= {CNT_W{1'b0}};
            shift_q     <= {RK_W{1'b0}};
            blk_q       <= {RK_W{1'b0}};
            blk_valid_q <= 1'b0;
            rk_valid_q  <= {NUM_RK{1'b0}};
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KEY_STP_TIMEOUT_EN
            stall_q     <= {ST_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            blk_q       <= blk_d;
            blk_valid_q <= blk_valid_d;
            rk_valid_q  <= rk_valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
`ifdef KEY_STP_TIMEOUT_EN
            stall_q     <= stall_d;
`endif
        end
    end

    rk_regfile #(
        .NUM_RK (NUM_RK)
    ) u_rk_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (we_s),
        .wr_idx  (idx_q),
        .wr_data (shift_q),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign busy      = busy_q;
    assign blk       = blk_q;
    assign blk_valid = blk_valid_q;
    assign rk_valid  = rk_valid_q;
    assign err       = err_q;

endmodule : key_stp_collect

// File: tb/tb_key_stp_collect.sv
// Self-checking bench for key_stp_collect: directed scenarios plus random
// frames, compared every cycle against a transaction-level reference model.
module tb_key_stp_collect;

    localparam int NRK  = 11;
    localparam int TOUT = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   kcnt;
    logic [7:0]   din;
    logic         din_valid;
    logic         busy;
    logic [127:0] blk;
    logic         blk_valid;
    logic [10:0]  rk_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_data;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;
    bit rnd_rd   = 1'b0;

    key_stp_collect #(.NUM_RK(NRK), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .kcnt(kcnt), .din(din),
        .din_valid(din_valid), .busy(busy), .blk(blk), .blk_valid(blk_valid),
        .rk_valid(rk_valid), .rd_idx(rd_idx), .rd_data(rd_data), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [127:0] m_slot [0:NRK-1];
    logic [10:0]  m_rkv;
    logic [127:0] m_blk, m_rd;
    bit           m_blkv, m_err, m_in_frame, m_commit;
    int           m_idx, m_stall;
    byte unsigned m_bytes [$];

    task automatic model_edge();
        logic [127:0] w;
        if (rst) begin
            for (int i = 0; i < NRK; i++) m_slot[i] = '0;
            m_rkv = '0; m_blk = '0; m_rd = '0; m_blkv = 0; m_err = 0;
            m_in_frame = 0; m_commit = 0; m_stall = 0; m_bytes.delete();
            return;
        end
        m_rd   = (int'(rd_idx) < NRK) ? m_slot[rd_idx] : '0;
        m_blkv = 0;
        if (m_commit) begin
            m_slot[m_idx] = m_blk;
            m_rkv[m_idx]  = 1'b1;
            m_commit      = 0;
            if (start || din_valid) m_err = 1;
        end else if (m_in_frame) begin
            if (start) m_err = 1;
            if (din_valid) begin
                m_bytes.push_back(din);
                m_stall = 0;
                if (m_bytes.size() == 16) begin
                    w = '0;
                    foreach (m_bytes[i]) w = (w << 8) | 128'(m_bytes[i]);
                    m_blk = w; m_blkv = 1; m_in_frame = 0; m_commit = 1;
                end
            end else begin
                m_stall++;
`ifdef KEY_STP_TIMEOUT_EN
                if (m_stall == TOUT) begin
                    m_in_frame = 0; m_err = 1; m_bytes.delete();
                end
`endif
            end
        end else if (start) begin
            if (int'(kcnt) < NRK) begin
                m_in_frame = 1; m_idx = int'(kcnt); m_bytes.delete(); m_stall = 0;
            end else begin
                m_err = 1;
            end
        end else if (din_valid) begin
            m_err = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic compare_all();
        chk("busy",      128'(busy),      128'(m_in_frame || m_commit));
        chk("blk",       blk,             m_blk);
        chk("blk_valid", 128'(blk_valid), 128'(m_blkv));
        chk("rk_valid",  128'(rk_valid),  128'(m_rkv));
        chk("rd_data",   rd_data,         m_rd);
        chk("err",       128'(err),       128'(m_err));
    endtask

    // One clock: inputs already set, model follows the edge, compare after.
    task automatic step();
        if (rnd_rd) rd_idx = 4'($urandom_range(0, 15));
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    // Start a frame and send 16 bytes; returns with the DUT in its commit cycle.
    task automatic frame(input logic [3:0] k, input logic [127:0] w, input int gap, input int bad_at);
        start = 1'b1; kcnt = k; step(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din = w[127 - 8*i -: 8]; din_valid = 1'b1; start = (i == bad_at);
            step();
            din_valid = 1'b0; start = 1'b0;
            if (i != 15) for (int g = 0; g < gap; g++) step();
        end
    endtask

    logic [127:0] w;

    initial begin
        rst = 1'b1; start = 1'b0; kcnt = 4'd0; din = 8'd0; din_valid = 1'b0; rd_idx = 4'd0;
        step(); step();
        rst = 1'b0;
        chk("reset_blk", blk, 128'd0);
        chk("reset_err", 128'(err), 128'd0);

        // Nominal frame to slot 3.
        frame(4'd3, 128'h000102030405060708090A0B0C0D0E0F, 0, -1);
        chk("nom_blk",  blk, 128'h000102030405060708090A0B0C0D0E0F);
        chk("nom_blkv", 128'(blk_valid), 128'd1);
        rd_idx = 4'd3; step();
        chk("nom_rkv",  128'(rk_valid), 128'h008);
        chk("nom_err",  128'(err), 128'd0);
        step();
        chk("nom_rd",   rd_data, 128'h000102030405060708090A0B0C0D0E0F);

        // Stalled frame to slot 10.
        frame(4'd10, 128'h2B7E151628AED2A6ABF7158809CF4F3C, 1, -1);
        rd_idx = 4'd10; step(); step();
        chk("stall_rd",  rd_data, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
        chk("stall_rkv", 128'(rk_valid[10]), 128'd1);

        // Protocol errors.
        do_reset();
        start = 1'b1; kcnt = 4'd11; step(); start = 1'b0;
        chk("bad_kcnt_busy", 128'(busy), 128'd0);
        chk("bad_kcnt_err",  128'(err),  128'd1);
        do_reset();
        din_valid = 1'b1; din = 8'h5A; step(); din_valid = 1'b0;
        chk("idle_din_err", 128'(err), 128'd1);
        do_reset();
        frame(4'd4, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 0, 5);
        chk("midstart_blk", blk, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F);
        chk("midstart_err", 128'(err), 128'd1);
        step();

        // Reset mid-frame, then a clean frame to slot 0.
        start = 1'b1; kcnt = 4'd1; step(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin din = 8'(i); din_valid = 1'b1; step(); end
        din_valid = 1'b0;
        do_reset();
        chk("rstmid_busy", 128'(busy), 128'd0);
        chk("rstmid_rkv",  128'(rk_valid), 128'd0);
        for (int i = 0; i < 20; i++) step();
        frame(4'd0, 128'h11223344556677889900AABBCCDDEEFF, 0, -1);
        step();
        chk("rstmid_rkv0", 128'(rk_valid), 128'h001);

        // Back-to-back writes to slot 5 with read-during-write.
        rd_idx = 4'd5;
        frame(4'd5, {16{8'hAA}}, 0, -1);
        step();
        frame(4'd5, {16{8'h55}}, 0, -1);
        chk("rdw_commit", rd_data, {16{8'hAA}});
        step();
        chk("rdw_old", rd_data, {16{8'hAA}});
        step();
        chk("rdw_new", rd_data, {16{8'h55}});

        // Inter-byte timeout scenario.
        do_reset();
        start = 1'b1; kcnt = 4'd2; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin din = 8'(8'h30 + i); din_valid = 1'b1; step(); end
        din_valid = 1'b0;
        for (int i = 0; i < TOUT; i++) step();
`ifdef KEY_STP_TIMEOUT_EN
        chk("tout_busy", 128'(busy), 128'd0);
        chk("tout_err",  128'(err),  128'd1);
        chk("tout_rkv",  128'(rk_valid), 128'd0);
`else
        chk("notout_busy", 128'(busy), 128'd1);
        for (int i = 4; i < 16; i++) begin din = 8'(8'h30 + i); din_valid = 1'b1; step(); end
        din_valid = 1'b0;
        chk("notout_blk", blk, 128'h303132333435363738393A3B3C3D3E3F);
        step();
        chk("notout_rkv", 128'(rk_valid), 128'h004);
`endif

        // Random frames with random stalls, noise and occasional resets.
        rnd_rd = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            w = {$urandom, $urandom, $urandom, $urandom};
            frame(4'($urandom_range(0, 12)), w, $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : -1);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                din_valid = ($urandom_range(0, 4) == 0);
                din = 8'($urandom);
                step();
                din_valid = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_key_stp_collect
